icache_nway_6502: RTL and testbench
===================================

ICACHE_NWAY_6502 -- requirements
Module: icache_nway_6502

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, number of fully-associative lines (power of 2, 1..8).
REQ-002 SHALL have parameter BLOCK_SIZE, default 8, bytes per line (power of 2, 4..32); OFF_W = log2(BLOCK_SIZE), TAG_W = 16-OFF_W.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 icache_en in 1 cache enable; low invalidates all lines.
REQ-007 skip_int in 1 with cpu_en low, marks the cycle as a no-op.
REQ-008 cpu_addr in 16; cpu_en in 1; cpu_wr in 1; cpu_iread in 1 (opcode/operand fetch); cpu_wdata in 8.
REQ-009 cpu_rdy out 1 CPU may advance; cpu_rdata out 8 registered read data.
REQ-010 int_en in 1 internal-memory select; int_rdata in 8 its data.
REQ-011 mem_addr out 24; mem_en out 1; mem_wr out 1; mem_rburst out 1; mem_wburst out 1; mem_wdata out 8.
REQ-012 mem_rdy in 1 (unused); mem_rdata0 in 8 beat data; mem_rdata_load in 1 beat strobe.
REQ-013 hit_count out CNT_WIDTH, miss_count out CNT_WIDTH: saturating statistics.

Function
REQ-014 States READY, MEM_WAIT, IFILL; cpu_rdy = 1 only in READY.
REQ-015 READY priority: (!cpu_en && skip_int) stay; else int_en: latch int_rdata, stay; else icache_en && any-way hit && !cpu_wr: latch hit byte, stay; else icache_en && cpu_iread && !cpu_wr: start fill, go IFILL; else mem_en=1, go MEM_WAIT.
REQ-016 Hit = valid[w] && tag[w] == cpu_addr[15:OFF_W]; at most one way hits; data byte selected by cpu_addr[OFF_W-1:0].
REQ-017 MEM_WAIT: mem_en=1, mem_addr={8'h00,cpu_addr}; on mem_rdata_load latch mem_rdata0 and go READY.
REQ-018 Fill start: mem_addr={8'h00,cpu_addr[15:OFF_W],OFF_W'b0}, mem_en=1, mem_rburst=1; save offset; victim way's valid cleared and tag loaded.
REQ-019 IFILL: mem_en=mem_rburst=1 until last beat; each mem_rdata_load writes mem_rdata0 into victim at fill_off, fill_off+1; cpu_rdata latched when fill_off == saved offset.
REQ-020 After BLOCK_SIZE beats: victim valid set, fill_off=0, victim pointer = (victim+1) mod NUM_WAYS, go READY.
REQ-021 Write-through: writes take MEM_WAIT path; if READY write cycle (no int_en) hits way w, byte cpu_wdata written into w at the same edge; no line allocated on write miss.
REQ-022 mem_wr=cpu_wr, mem_wdata=cpu_wdata, mem_wburst=0, combinational.
REQ-023 hit_count +1 per READY read hit (REQ-015 branch 3); miss_count +1 per fill start; both hold at all-ones.
REQ-024 icache_en low: all valid bits cleared, victim=0, each cycle; counters hold; reads go MEM_WAIT.
REQ-025 A fill in progress when icache_en falls completes its beats but sets no valid bit.

Reset
REQ-026 rst SHALL force state READY, all valid=0, victim=0, fill_off=0, cpu_rdata=8'h00, counters=0, regardless of state (incl. mid-fill); tag/data arrays not reset.
REQ-027 Reset outputs: cpu_rdy=1, mem_en=0, mem_rburst=0, mem_wburst=0.

Structure
REQ-028 State enum and BLOCK_SIZE/NUM_WAYS derivation functions SHALL live in shared package cache_pkg.
REQ-029 One sub-module cache_way (tag, valid, BLOCK_SIZE-byte data, fill and write-hit ports), instantiated NUM_WAYS times via generate.

Verification
REQ-030 NUM_WAYS=2, BLOCK_SIZE=8: iread 16'h1234 cold -> one 8-beat burst at 24'h001230, cpu_rdata=beat 4 data, miss_count=1; re-read 16'h1237 -> zero-wait hit, hit_count=1.
REQ-031 Fill 16'h1000, 16'h2000, 16'h3000 -> third fill evicts way 0; read 16'h1000 misses, 16'h2000 hits.
REQ-032 Write 8'hA5 to cached 16'h1232 -> MEM_WAIT write issued, subsequent read returns 8'hA5 with no burst.
REQ-033 rst asserted at fill beat 3 -> next cycle READY, mem_en=0, counters 0, prior line misses.
REQ-034 icache_en low one cycle, then reread cached address -> miss and fresh fill; int_en read -> int_rdata, no mem_en.
REQ-035 Force hit_count to all-ones-1, two hits -> saturates at all-ones.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants, FSM encodings and size-derivation helpers for the 6502 instruction cache.
package cache_pkg;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned MEM_ADDR_W = 24;

    localparam logic [1:0] ST_READY    = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_IFILL    = 2'd2;

    // Outbound memory request, assembled combinationally then split onto ports.
    typedef struct packed {
        logic                  en;
        logic                  rburst;
        logic [MEM_ADDR_W-1:0] addr;
    } mem_req_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 32'd1;
        end
        return r;
    endfunction

    function automatic int unsigned off_w(input int unsigned block_size);
        return clog2_u(block_size);
    endfunction

    function automatic int unsigned tag_w(input int unsigned block_size);
        return ADDR_W - off_w(block_size);
    endfunction

    // A single-way cache still needs a 1-bit way index.
    function automatic int unsigned way_w(input int unsigned num_ways);
        return (num_ways < 32'd2) ? 32'd1 : clog2_u(num_ways);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One fully-associative cache line: valid bit, tag and BLOCK_SIZE data bytes.
module cache_way
    import cache_pkg::*;
#(
    parameter  int unsigned BLOCK_SIZE = 8,
    localparam int unsigned OFF_W      = off_w(BLOCK_SIZE),
    localparam int unsigned TAG_W      = tag_w(BLOCK_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inv_all,
    input  logic             alloc,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             fill_we,
    input  logic [OFF_W-1:0] fill_off,
    input  logic [7:0]       fill_data,
    input  logic             fill_done,
    input  logic             wr_en,
    input  logic [OFF_W-1:0] wr_off,
    input  logic [7:0]       wr_data,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [OFF_W-1:0] rd_off,
    output logic             hit_c,
    output logic [7:0]       rd_data_c
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [7:0]       data_q [BLOCK_SIZE];
    logic [7:0]       data_d [BLOCK_SIZE];

    // Next line state: allocation clears valid, completion sets it, invalidate wins.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (alloc) begin
            valid_d = 1'b0;
            tag_d   = alloc_tag;
        end
        if (fill_done) valid_d = 1'b1;
        if (inv_all)   valid_d = 1'b0;
        if (fill_we)   data_d[fill_off] = fill_data;
        if (wr_en)     data_d[wr_off]   = wr_data;
    end

    // Valid bit is the only reset state of the line.
    always_ff @(posedge clk) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Tag and data storage carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign hit_c     = valid_q && (tag_q == lookup_tag);
    assign rd_data_c = data_q[rd_off];

endmodule

// File: rtl/icache_nway_6502.sv
// N-way fully-associative, write-through instruction cache for a 6502-class CPU.
module icache_nway_6502
    import cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_en,
    input  logic                  skip_int,
    input  logic [15:0]           cpu_addr,
    input  logic                  cpu_en,
    input  logic                  cpu_wr,
    input  logic                  cpu_iread,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_rdy,
    output logic [7:0]            cpu_rdata,
    input  logic                  int_en,
    input  logic [7:0]            int_rdata,
    output logic [23:0]           mem_addr,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic                  mem_rburst,
    output logic                  mem_wburst,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_rdy,
    input  logic [7:0]            mem_rdata0,
    input  logic                  mem_rdata_load,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int unsigned OFF_W = off_w(BLOCK_SIZE);
    localparam int unsigned TAG_W = tag_w(BLOCK_SIZE);
    localparam int unsigned WAY_W = way_w(NUM_WAYS);

    logic [1:0]           state_q, state_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic [WAY_W-1:0]     fill_way_q, fill_way_d;
    logic [OFF_W-1:0]     fill_off_q, fill_off_d;
    logic [OFF_W-1:0]     save_off_q, save_off_d;
    logic [TAG_W-1:0]     fill_tag_q, fill_tag_d;
    logic                 fill_kill_q, fill_kill_d;
    logic [7:0]           cpu_rdata_q, cpu_rdata_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]     cpu_tag;
    logic [OFF_W-1:0]     cpu_off;
    logic [NUM_WAYS-1:0]  way_hit;
    logic [7:0]           way_rdata [NUM_WAYS];
    logic                 any_hit;
    logic [7:0]           hit_data;

    logic                 inv_all;
    logic                 alloc;
    logic                 fill_we;
    logic                 fill_done;
    logic                 wr_hit;
    logic [NUM_WAYS-1:0]  alloc_v, fill_we_v, fill_done_v, wr_en_v;
    mem_req_t             mem_req;

    // Bus ready is not used: beat timing comes from mem_rdata_load alone.
    logic                 unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;

    assign cpu_tag = cpu_addr[15:OFF_W];
    assign cpu_off = cpu_addr[OFF_W-1:0];

    // Merge per-way lookups; tags are unique so at most one way hits.
    always_comb begin
        any_hit  = 1'b0;
        hit_data = 8'h00;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (way_hit[i]) begin
                any_hit  = 1'b1;
                hit_data = hit_data | way_rdata[i];
            end
        end
    end

    // Controller: next state, line control and memory request.
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        fill_way_d  = fill_way_q;
        fill_off_d  = fill_off_q;
        save_off_d  = save_off_q;
        fill_tag_d  = fill_tag_q;
        fill_kill_d = fill_kill_q;
        cpu_rdata_d = cpu_rdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        inv_all     = 1'b0;
        alloc       = 1'b0;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        wr_hit      = 1'b0;
        mem_req     = '0;

        case (state_q)
            ST_READY: begin
                if (!cpu_en && skip_int) begin
                    state_d = ST_READY;
                end else if (int_en) begin
                    cpu_rdata_d = int_rdata;
                end else if (icache_en && any_hit && !cpu_wr) begin
                    cpu_rdata_d = hit_data;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                end else if (icache_en && cpu_iread && !cpu_wr) begin
                    mem_req.en     = 1'b1;
                    mem_req.rburst = 1'b1;
                    mem_req.addr   = {8'h00, cpu_tag, {OFF_W{1'b0}}};
                    alloc          = 1'b1;
                    fill_way_d     = victim_q;
                    fill_tag_d     = cpu_tag;
                    save_off_d     = cpu_off;
                    fill_off_d     = '0;
                    fill_kill_d    = 1'b0;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                    state_d        = ST_IFILL;
                end else begin
                    mem_req.en   = 1'b1;
                    mem_req.addr = {8'h00, cpu_addr};
                    wr_hit       = cpu_wr && icache_en && any_hit;
                    state_d      = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                mem_req.en   = 1'b1;
                mem_req.addr = {8'h00, cpu_addr};
                if (mem_rdata_load) begin
                    cpu_rdata_d = mem_rdata0;
                    state_d     = ST_READY;
                end
            end
            ST_IFILL: begin
                mem_req.en     = 1'b1;
                mem_req.rburst = 1'b1;
                mem_req.addr   = {8'h00, fill_tag_q, {OFF_W{1'b0}}};
                if (!icache_en) fill_kill_d = 1'b1;
                if (mem_rdata_load) begin
                    fill_we    = 1'b1;
                    fill_off_d = fill_off_q + OFF_W'(1);
                    if (fill_off_q == save_off_q) cpu_rdata_d = mem_rdata0;
                    if (fill_off_q == OFF_W'(BLOCK_SIZE - 1)) begin
                        fill_off_d = '0;
                        fill_done  = !fill_kill_q && icache_en;
                        victim_d   = (victim_q == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                       : victim_q + WAY_W'(1);
                        state_d    = ST_READY;
                    end
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        // A disabled cache forgets everything, every cycle.
        if (!icache_en) begin
            inv_all  = 1'b1;
            victim_d = '0;
        end
    end

    // Steer line controls to the selected way.
    always_comb begin
        alloc_v     = '0;
        fill_we_v   = '0;
        fill_done_v = '0;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            alloc_v[i]     = alloc     && (victim_q   == WAY_W'(i));
            fill_we_v[i]   = fill_we   && (fill_way_q == WAY_W'(i));
            fill_done_v[i] = fill_done && (fill_way_q == WAY_W'(i));
        end
        wr_en_v = way_hit & {NUM_WAYS{wr_hit}};
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_READY;
            victim_q    <= '0;
            fill_way_q  <= '0;
            fill_off_q  <= '0;
            save_off_q  <= '0;
            fill_tag_q  <= '0;
            fill_kill_q <= 1'b0;
            cpu_rdata_q <= 8'h00;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            fill_way_q  <= fill_way_d;
            fill_off_q  <= fill_off_d;
            save_off_q  <= save_off_d;
            fill_tag_q  <= fill_tag_d;
            fill_kill_q <= fill_kill_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        cache_way #(
            .BLOCK_SIZE (BLOCK_SIZE)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .inv_all    (inv_all),
            .alloc      (alloc_v[gi]),
            .alloc_tag  (cpu_tag),
            .fill_we    (fill_we_v[gi]),
            .fill_off   (fill_off_q),
            .fill_data  (mem_rdata0),
            .fill_done  (fill_done_v[gi]),
            .wr_en      (wr_en_v[gi]),
            .wr_off     (cpu_off),
            .wr_data    (cpu_wdata),
            .lookup_tag (cpu_tag),
            .rd_off     (cpu_off),
            .hit_c      (way_hit[gi]),
            .rd_data_c  (way_rdata[gi])
        );
    end

    assign cpu_rdy    = (state_q == ST_READY);
    assign cpu_rdata  = cpu_rdata_q;
    assign mem_en     = mem_req.en && !rst;
    assign mem_rburst = mem_req.rburst && !rst;
    assign mem_addr   = mem_req.addr;
    assign mem_wr     = cpu_wr;
    assign mem_wdata  = cpu_wdata;
    assign mem_wburst = 1'b0;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_nway_6502.sv
// Randomized bench for icache_nway_6502 against a line-level cache model.
module tb_icache_nway_6502;

    localparam int NW   = 2;
    localparam int BS   = 8;
    localparam int CW   = 4;
    localparam int HMAX = 15;

    logic          clk = 1'b0;
    logic          rst, icache_en, skip_int, cpu_en, cpu_wr, cpu_iread, int_en;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_wdata, int_rdata, mem_rdata0, mem_wdata, cpu_rdata;
    logic          mem_rdy, mem_rdata_load;
    logic          cpu_rdy, mem_en, mem_wr, mem_rburst, mem_wburst;
    logic [23:0]   mem_addr;
    logic [CW-1:0] hit_count, miss_count;

    icache_nway_6502 #(.NUM_WAYS(NW), .BLOCK_SIZE(BS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .icache_en(icache_en), .skip_int(skip_int),
        .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_iread(cpu_iread),
        .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
        .int_en(int_en), .int_rdata(int_rdata), .mem_addr(mem_addr), .mem_en(mem_en),
        .mem_wr(mem_wr), .mem_rburst(mem_rburst), .mem_wburst(mem_wburst),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata0(mem_rdata0),
        .mem_rdata_load(mem_rdata_load), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Backing memory; with write-through, any cached byte must equal it.
    logic [7:0]  mem [0:65535];
    // Line-level model: which tags are resident, FIFO replacement pointer, statistics.
    bit          m_valid [NW];
    logic [12:0] m_tag   [NW];
    int          m_victim;
    int          m_hits;
    int          m_miss;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        for (int w = 0; w < NW; w++)
            if (m_valid[w] && m_tag[w] == a[15:3]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_flush();
        for (int w = 0; w < NW; w++) m_valid[w] = 1'b0;
        m_victim = 0;
    endtask

    task automatic go_idle();
        cpu_en = 1'b0; skip_int = 1'b1; int_en = 1'b0; cpu_wr = 1'b0; cpu_iread = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_hits"}, 32'(hit_count), 32'(m_hits));
        check_eq({tag, "_miss"}, 32'(miss_count), 32'(m_miss));
    endtask

    // One CPU access, from presentation to the cycle cpu_rdy returns.
    task automatic do_access(input logic [15:0] addr, input logic wr, input logic iread,
                             input logic [7:0] wdata, input logic use_int);
        logic [7:0]  idata, rd;
        logic [15:0] base;
        bit          hit;
        hit       = model_hit(addr);
        base      = addr & 16'hFFF8;
        idata     = 8'($urandom);
        cpu_addr  = addr; cpu_wr = wr; cpu_iread = iread; cpu_wdata = wdata;
        cpu_en    = 1'b1; skip_int = 1'b0; int_en = use_int; int_rdata = idata;
        #1;
        check_eq("rdy_pre", 32'(cpu_rdy), 32'd1);
        if (use_int) begin
            check_eq("int_mem_en", 32'(mem_en), 32'd0);
            @(posedge clk); #1; go_idle(); #1;
            check_eq("int_rdata", 32'(cpu_rdata), 32'(idata));
        end else if (hit && !wr) begin
            check_eq("hit_mem_en", 32'(mem_en), 32'd0);
            @(posedge clk); #1; go_idle(); #1;
            if (m_hits < HMAX) m_hits++;
            check_eq("hit_rdata", 32'(cpu_rdata), 32'(mem[addr]));
            check_eq("hit_rdy", 32'(cpu_rdy), 32'd1);
        end else if (iread && !wr) begin
            check_eq("fill_req", 32'({mem_en, mem_rburst, mem_wburst}), 32'b110);
            check_eq("fill_addr", 32'(mem_addr), 32'({8'h00, base}));
            @(posedge clk); #1;
            if (m_miss < HMAX) m_miss++;
            m_valid[m_victim] = 1'b0;
            m_tag[m_victim]   = addr[15:3];
            check_eq("fill_rdy", 32'(cpu_rdy), 32'd0);
            for (int b = 0; b < BS; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    check_eq("fill_gap", 32'({mem_en, mem_rburst}), 32'b11);
                    @(posedge clk); #1;
                end
                mem_rdata0     = mem[base + 16'(b)];
                mem_rdata_load = 1'b1;
                #1;
                check_eq("fill_beat", 32'({mem_en, mem_rburst, cpu_rdy}), 32'b110);
                @(posedge clk); #1;
                mem_rdata_load = 1'b0;
                mem_rdata0     = 8'($urandom);
            end
            go_idle(); #1;
            m_valid[m_victim] = 1'b1;
            m_victim = (m_victim + 1) % NW;
            check_eq("fill_done_rdy", 32'(cpu_rdy), 32'd1);
            check_eq("fill_rdata", 32'(cpu_rdata), 32'(mem[addr]));
            check_eq("fill_idle_en", 32'(mem_en), 32'd0);
        end else begin
            check_eq("mw_req", 32'({mem_en, mem_rburst, mem_wr}), 32'({1'b1, 1'b0, wr}));
            check_eq("mw_addr", 32'(mem_addr), 32'({8'h00, addr}));
            if (wr) check_eq("mw_wdata", 32'(mem_wdata), 32'(wdata));
            if (wr) mem[addr] = wdata;
            @(posedge clk); #1;
            check_eq("mw_rdy", 32'(cpu_rdy), 32'd0);
            repeat ($urandom_range(0, 2)) begin
                check_eq("mw_hold", 32'(mem_en), 32'd1);
                @(posedge clk); #1;
            end
            rd             = wr ? 8'($urandom) : mem[addr];
            mem_rdata0     = rd;
            mem_rdata_load = 1'b1;
            @(posedge clk); #1;
            mem_rdata_load = 1'b0;
            go_idle(); #1;
            check_eq("mw_rdata", 32'(cpu_rdata), 32'(rd));
            check_eq("mw_done_rdy", 32'(cpu_rdy), 32'd1);
        end
        check_counts("ctr");
    endtask

    task automatic toggle_icache();
        icache_en = 1'b0;
        @(posedge clk); #1;
        icache_en = 1'b1;
        #1;
        model_flush();
    endtask

    initial begin
        logic [15:0] pool [5];
        logic [15:0] a;
        int          op;
        pool[0] = 16'h1000; pool[1] = 16'h2000; pool[2] = 16'h3000;
        pool[3] = 16'h1230; pool[4] = 16'h4568;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst = 1'b1; icache_en = 1'b1; mem_rdy = 1'b1; mem_rdata_load = 1'b0;
        mem_rdata0 = 8'h00; int_rdata = 8'h00; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        go_idle();
        model_flush(); m_hits = 0; m_miss = 0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;

        check_eq("rst_rdy", 32'(cpu_rdy), 32'd1);
        check_eq("rst_mem", 32'({mem_en, mem_rburst, mem_wburst}), 32'd0);
        check_eq("rst_rdata", 32'(cpu_rdata), 32'd0);
        check_counts("rst");

        // Cold fetch, then a zero-wait hit in the same line.
        do_access(16'h1234, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("cold_miss", 32'(miss_count), 32'd1);
        do_access(16'h1237, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("warm_hit", 32'(hit_count), 32'd1);

        // Write-through hit updates the line; readback served from cache.
        do_access(16'h1232, 1'b1, 1'b0, 8'hA5, 1'b0);
        do_access(16'h1232, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("wr_hit_data", 32'(cpu_rdata), 32'hA5);

        // FIFO replacement from an empty cache.
        toggle_icache();
        do_access(16'h1000, 1'b0, 1'b1, 8'h00, 1'b0);
        do_access(16'h2000, 1'b0, 1'b1, 8'h00, 1'b0);
        do_access(16'h3000, 1'b0, 1'b1, 8'h00, 1'b0);
        do_access(16'h2000, 1'b0, 1'b1, 8'h00, 1'b0);
        do_access(16'h1000, 1'b0, 1'b0, 8'h00, 1'b0);

        // Disable one cycle forces a refetch; internal-memory read bypasses the bus.
        toggle_icache();
        do_access(16'h3000, 1'b0, 1'b1, 8'h00, 1'b0);
        do_access(16'h3003, 1'b0, 1'b1, 8'h00, 1'b1);

        // Reset in the middle of a burst.
        cpu_addr = 16'h4000; cpu_iread = 1'b1; cpu_wr = 1'b0; cpu_en = 1'b1; skip_int = 1'b0;
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) begin
            mem_rdata0 = mem[16'h4000 + 16'(b)]; mem_rdata_load = 1'b1;
            @(posedge clk); #1;
            mem_rdata_load = 1'b0;
        end
        rst = 1'b1; #1;
        check_eq("rst_mid_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; go_idle(); #1;
        model_flush(); m_hits = 0; m_miss = 0;
        check_eq("rst_mid_rdy", 32'(cpu_rdy), 32'd1);
        check_eq("rst_mid_mem", 32'({mem_en, mem_rburst}), 32'd0);
        check_counts("rst_mid");
        do_access(16'h3000, 1'b0, 1'b1, 8'h00, 1'b0);

        // Randomized mix over a few conflicting lines.
        for (int n = 0; n < 300; n++) begin
            a  = pool[$urandom_range(0, 4)] | 16'($urandom_range(0, 7));
            op = $urandom_range(0, 99);
            if      (op < 55) do_access(a, 1'b0, 1'b1, 8'h00, 1'b0);
            else if (op < 70) do_access(a, 1'b0, 1'b0, 8'h00, 1'b0);
            else if (op < 88) do_access(a, 1'b1, 1'b0, 8'($urandom), 1'b0);
            else if (op < 95) do_access(a, 1'b0, 1'b1, 8'h00, 1'b1);
            else              toggle_icache();
        end

        // Hit counter saturates at all-ones.
        do_access(16'h1230, 1'b0, 1'b1, 8'h00, 1'b0);
        for (int n = 0; n < HMAX + 4; n++) do_access(16'h1231, 1'b0, 1'b1, 8'h00, 1'b0);
        check_eq("hit_sat", 32'(hit_count), 32'(HMAX));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound so a stuck design cannot hang the run.
    initial begin
        #2000000;
        $display("FAIL timeout tests=%0d", tests_run);
        $fatal(1, "timeout");
    end

endmodule
